// File: rtl/axil_reg_master_pkg.sv
// Shared types and constants for the axil_reg_master AXI4-Lite command initiator.
// Optional hang recovery is enabled by defining AXIL_REG_MASTER_TIMEOUT_EN.

package axil_reg_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

    // Latched command payload; the address is held separately at AXI width.
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } rsp_t;

endpackage

// File: rtl/axil_reg_master.sv
// Single-outstanding AXI4-Lite initiator: one valid/ready command in, one response out.
// Define AXIL_REG_MASTER_TIMEOUT_EN to force-complete transactions after C_TIMEOUT_CYCLES.

module axil_reg_master
    import axil_reg_master_pkg::*;
#(
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS     = '0,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                   C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    state_e                          r_state;
    state_e                          w_state_next;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
    cmd_t                            r_cmd;
    rsp_t                            r_rsp;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_cmd_en;

    logic                            w_accept;
    logic                            w_aw_done;
    logic                            w_w_done;
    logic                            w_step_done;
    logic                            w_timeout;
    logic                            w_force;

    logic                            w_cmd_ready;
    logic                            w_arvalid;
    logic                            w_bready;
    logic                            w_rready;
    logic                            w_rsp_valid;

    assign w_accept = cmd_valid & w_cmd_ready;

`ifdef AXIL_REG_MASTER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(C_TIMEOUT_CYCLES - 1);

    logic [31:0] r_cnt;
    logic        w_wait;

    assign w_wait = (r_state == StWrReq) || (r_state == StWrResp) ||
                    (r_state == StRdReq) || (r_state == StRdResp);

    // Saturates at the last count so a late stage still sees the expiry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_wait && (r_cnt != TIMEOUT_LAST)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign w_timeout = w_wait && (r_cnt == TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Stage completion; a completing handshake always beats an expiring timer.
    always_comb begin
        w_aw_done   = ~r_awvalid | M_AXI_AWREADY;
        w_w_done    = ~r_wvalid | M_AXI_WREADY;
        w_step_done = 1'b0;
        case (r_state)
            StWrReq:  w_step_done = w_aw_done & w_w_done;
            StWrResp: w_step_done = M_AXI_BVALID;
            StRdReq:  w_step_done = M_AXI_ARREADY;
            StRdResp: w_step_done = M_AXI_RVALID;
            default:  w_step_done = 1'b0;
        endcase
        w_force = w_timeout & ~w_step_done;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = cmd_wr ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                if (w_step_done) begin
                    w_state_next = StWrResp;
                end else if (w_force) begin
                    w_state_next = StRsp;
                end
            end
            StWrResp: begin
                if (w_step_done || w_force) begin
                    w_state_next = StRsp;
                end
            end
            StRdReq: begin
                if (w_step_done) begin
                    w_state_next = StRdResp;
                end else if (w_force) begin
                    w_state_next = StRsp;
                end
            end
            StRdResp: begin
                if (w_step_done || w_force) begin
                    w_state_next = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // r_cmd_en keeps cmd_ready low while reset is held and for the first cycle after.
    always_comb begin
        w_cmd_ready = 1'b0;
        w_arvalid   = 1'b0;
        w_bready    = 1'b0;
        w_rready    = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            StIdle:   w_cmd_ready = r_cmd_en;
            StWrResp: w_bready    = 1'b1;
            StRdReq:  w_arvalid   = 1'b1;
            StRdResp: w_rready    = 1'b1;
            StRsp:    w_rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_cmd     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_rsp     <= '0;
            r_cmd_en  <= 1'b0;
        end else begin
            r_cmd_en <= 1'b1;

            if (w_accept) begin
                r_addr    <= cmd_addr ^ C_BASE_ADDRESS;
                r_cmd     <= '{wdata: cmd_wdata, wstrb: cmd_wstrb};
                r_awvalid <= cmd_wr;
                r_wvalid  <= cmd_wr;
            end else if (w_force) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
            end else begin
                r_awvalid <= r_awvalid & ~M_AXI_AWREADY;
                r_wvalid  <= r_wvalid & ~M_AXI_WREADY;
            end

            if (w_force) begin
                r_rsp <= '{rdata: TIMEOUT_RDATA, resp: AXI_RESP_SLVERR, timeout: 1'b1};
            end else if ((r_state == StWrResp) && M_AXI_BVALID) begin
                r_rsp <= '{rdata: '0, resp: M_AXI_BRESP, timeout: 1'b0};
            end else if ((r_state == StRdResp) && M_AXI_RVALID) begin
                r_rsp <= '{rdata: M_AXI_RDATA, resp: M_AXI_RRESP, timeout: 1'b0};
            end
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign rsp_valid     = w_rsp_valid;
    assign rsp_rdata     = r_rsp.rdata;
    assign rsp_resp      = r_rsp.resp;
    assign rsp_timeout   = r_rsp.timeout;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_cmd.wdata;
    assign M_AXI_WSTRB   = r_cmd.wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = w_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = w_arvalid;
    assign M_AXI_RREADY  = w_rready;

endmodule
